// File: rtl/dual_sine_ctrl_if.sv
// dual_sine_ctrl_if
//   Bundles the two buses around the sine sequencer:
//   - offset request handshake: offset_in, offset_valid (requester -> ctrl),
//     offset_ready (ctrl -> requester)
//   - dual-port ROM bus: addr1, addr2, offset (ctrl -> ROM),
//     dout1, dout2 (ROM -> ctrl, combinational read data)
//   Modport slave is the sequencer's view; master is the requester/ROM side.
interface dual_sine_ctrl_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
);
  logic [ADDRESS_WIDTH-1:0] offset_in;
  logic                     offset_valid;
  logic                     offset_ready;
  logic [ADDRESS_WIDTH-1:0] addr1;
  logic [ADDRESS_WIDTH-1:0] addr2;
  logic [ADDRESS_WIDTH-1:0] offset;
  logic [DATA_WIDTH-1:0]    dout1;
  logic [DATA_WIDTH-1:0]    dout2;

  modport slave (
    input  offset_in, offset_valid, dout1, dout2,
    output offset_ready, addr1, addr2, offset
  );

  modport master (
    output offset_in, offset_valid, dout1, dout2,
    input  offset_ready, addr1, addr2, offset
  );
endinterface

// File: rtl/dual_sine_ctrl.sv
// dual_sine_ctrl
//   Sequencer for a dual-port sine ROM. Steps a shared phase address by a
//   programmable increment, owns the channel-2 offset register (updated via a
//   valid/ready handshake and committed only on a phase wrap while running),
//   and registers both ROM outputs as a qualified sample pair.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, stop       start a burst from IDLE / abort RUN (stop wins)
//   burst_len         samples per burst, 0 = continuous (sampled at start)
//   incr              phase step (sampled at start)
//   bus               offset handshake + ROM address/data (slave modport)
//   sample1, sample2  registered ROM data, qualified by sample_valid
//   busy              state is not IDLE
//   done              one-cycle pulse at the end of a finite burst
module dual_sine_ctrl #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [15:0]              burst_len,
  input  logic [ADDRESS_WIDTH-1:0] incr,
  dual_sine_ctrl_if.slave          bus,
  output logic [DATA_WIDTH-1:0]    sample1,
  output logic [DATA_WIDTH-1:0]    sample2,
  output logic                     sample_valid,
  output logic                     busy,
  output logic                     done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]               state;
  logic [ADDRESS_WIDTH-1:0] phase;
  logic [ADDRESS_WIDTH-1:0] incr_r;
  logic [ADDRESS_WIDTH-1:0] offset_r;
  logic [ADDRESS_WIDTH-1:0] pend_val;
  logic [15:0]              len_r;
  logic [15:0]              count;
  logic                     pending;
  logic [ADDRESS_WIDTH:0]   phase_sum;
  logic                     wrap;
  logic                     last;

  // The carry out of the phase addition marks a wrap back through zero.
  assign phase_sum = {1'b0, phase} + {1'b0, incr_r};
  assign wrap      = phase_sum[ADDRESS_WIDTH];
  assign last      = (len_r != 16'd0) && (count == len_r - 16'd1);

  assign bus.addr1        = phase;
  assign bus.addr2        = phase;
  assign bus.offset       = offset_r;
  assign bus.offset_ready = !pending;
  assign busy             = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      phase        <= '0;
      incr_r       <= '0;
      len_r        <= '0;
      count        <= '0;
      sample1      <= '0;
      sample2      <= '0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          phase        <= '0;
          sample_valid <= 1'b0;
          done         <= 1'b0;
          if (start && !stop) begin
            incr_r <= incr;
            len_r  <= burst_len;
            count  <= '0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          sample1 <= bus.dout1;
          sample2 <= bus.dout2;
          // Saturate so long continuous playback never wraps the counter.
          if (count != 16'hFFFF) count <= count + 16'd1;
          if (stop) begin
            // The sample captured this cycle is discarded by leaving valid low.
            state        <= ST_IDLE;
            phase        <= '0;
            sample_valid <= 1'b0;
          end else begin
            phase        <= phase_sum[ADDRESS_WIDTH-1:0];
            sample_valid <= 1'b1;
            if (last) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state        <= ST_IDLE;
          phase        <= '0;
          sample_valid <= 1'b0;
          done         <= 1'b0;
        end
        default: begin
          state        <= ST_IDLE;
          phase        <= '0;
          sample_valid <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end

  // Offset request: one entry deep. While running, the commit waits for a
  // wrap so channel 2 only changes at a cycle boundary; otherwise it lands
  // the cycle after the transfer. Ready is low while pending, so transfer
  // and commit can never happen in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      pend_val <= '0;
      offset_r <= '0;
    end else if (pending) begin
      if ((state != ST_RUN) || wrap) begin
        offset_r <= pend_val;
        pending  <= 1'b0;
      end
    end else if (bus.offset_valid) begin
      pend_val <= bus.offset_in;
      pending  <= 1'b1;
    end
  end

endmodule
